// File: rtl/hc595_shifter.sv
// rtl/hc595_shifter.sv - serial driver for two cascaded 74HC595 feeding the 6-digit display
module hc595_shifter #(
    parameter int SHCP_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       done
);

    localparam int PW = (SHCP_DIV > 2) ? $clog2(SHCP_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST       = PW'(SHCP_DIV - 1);
    localparam logic [PW-1:0] PH_HALF       = PW'(SHCP_DIV / 2);
    localparam logic [PW-1:0] PH_LATCH_LAST = PW'(SHCP_DIV / 2 - 1);
    localparam logic [3:0]    BIT_LAST      = 4'd13;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [13:0]     shreg_q, shreg_d;
    logic            ds_q, ds_d;
    logic            shcp_q, shcp_d;
    logic            stcp_q, stcp_d;
    logic            in_ready_q, in_ready_d;
    logic            done_q, done_d;
    logic            oe_q, oe_d;

    logic [PW-1:0]   phase_nx;
    logic [13:0]     load_vec;

    // Frame laid out so that the LSB leaves first: seg[0]..seg[7], then sel[5]..sel[0].
    assign load_vec = {sel[0], sel[1], sel[2], sel[3], sel[4], sel[5], seg};
    assign phase_nx = phase_q + 1'b1;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        ds_d       = 1'b0;
        shcp_d     = 1'b0;
        stcp_d     = 1'b0;
        in_ready_d = 1'b0;
        done_d     = 1'b0;
        oe_d       = oe_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = SHIFT;
                    phase_d = '0;
                    bit_d   = '0;
                    shreg_d = load_vec;
                    ds_d    = load_vec[0];
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                        stcp_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = shreg_q >> 1;
                        ds_d    = shreg_q[1];
                    end
                end else begin
                    phase_d = phase_nx;
                    ds_d    = shreg_q[0];
                    shcp_d  = (phase_nx >= PH_HALF);
                end
            end
            LATCH: begin
                if (phase_q == PH_LATCH_LAST) begin
                    state_d    = IDLE;
                    phase_d    = '0;
                    done_d     = 1'b1;
                    in_ready_d = 1'b1;
                    oe_d       = 1'b0;
                end else begin
                    phase_d = phase_nx;
                    stcp_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame without latching it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            ds_q       <= 1'b0;
            shcp_q     <= 1'b0;
            stcp_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            oe_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            ds_q       <= ds_d;
            shcp_q     <= shcp_d;
            stcp_q     <= stcp_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            oe_q       <= oe_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ds       = ds_q;
    assign shcp     = shcp_q;
    assign stcp     = stcp_q;
    assign oe       = oe_q;
    assign done     = done_q;

endmodule

// File: tb/tb_hc595_shifter.sv
// tb/tb_hc595_shifter.sv - self-checking bench for hc595_shifter
module tb_hc595_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, iv4, rdy4, ds4, shcp4, stcp4, oe4, done4;
    logic [5:0] sel4;
    logic [7:0] seg4;
    logic       rst2, iv2, rdy2, ds2, shcp2, stcp2, oe2, done2;
    logic [5:0] sel2;
    logic [7:0] seg2;

    hc595_shifter #(.SHCP_DIV(4)) u4 (
        .sys_clk(clk), .sys_rst(rst4), .sel(sel4), .seg(seg4), .in_valid(iv4),
        .in_ready(rdy4), .ds(ds4), .shcp(shcp4), .stcp(stcp4), .oe(oe4), .done(done4)
    );

    hc595_shifter #(.SHCP_DIV(2)) u2 (
        .sys_clk(clk), .sys_rst(rst2), .sel(sel2), .seg(seg2), .in_valid(iv2),
        .in_ready(rdy2), .ds(ds2), .shcp(shcp2), .stcp(stcp2), .oe(oe2), .done(done2)
    );

    // observed vector layout: {ds, shcp, stcp, done, in_ready, oe}
    wire [5:0] obs4 = {ds4, shcp4, stcp4, done4, rdy4, oe4};
    wire [5:0] obs2 = {ds2, shcp2, stcp2, done2, rdy2, oe2};

    int   n_cmp = 0;
    int   n_bad = 0;
    logic oe_st4 = 1'b1;
    logic oe_st2 = 1'b1;

    // bit k of the result is the k-th bit sent on ds
    function automatic logic [13:0] frame_bits(input logic [5:0] s, input logic [7:0] g);
        logic [13:0] b;
        for (int k = 0; k < 14; k++) b[k] = (k < 8) ? g[k] : s[13 - k];
        return b;
    endfunction

    // expected outputs o cycles after the accept cycle (o >= 1)
    function automatic logic [5:0] expect_at(input logic [13:0] b, input int o, input int div,
                                             input logic oe_before);
        logic [5:0] e;
        if (o <= 14 * div)
            e = {b[(o - 1) / div], (((o - 1) % div) >= div / 2), 1'b0, 1'b0, 1'b0, oe_before};
        else if (o <= 14 * div + div / 2)
            e = {2'b00, 1'b1, 2'b00, oe_before};
        else
            e = 6'b000110;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready4();
        int n = 0;
        while (!rdy4 && n < 10) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!rdy4) begin
            n_bad++;
            $display("FAIL wait_ready4 in_ready=%b required=1", rdy4);
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst2 = 1'b1;
        iv4 = 1'b1; iv2 = 1'b1;
        sel4 = 6'($urandom); seg4 = 8'($urandom);
        sel2 = 6'($urandom); seg2 = 8'($urandom);
        repeat (3) tick();
        n_cmp++;
        if (obs4 !== 6'b000001) begin n_bad++; $display("FAIL reset_vals4 got=%b exp=%b", obs4, 6'b000001); end
        n_cmp++;
        if (obs2 !== 6'b000001) begin n_bad++; $display("FAIL reset_vals2 got=%b exp=%b", obs2, 6'b000001); end
        rst4 = 1'b0; rst2 = 1'b0;
        iv4 = 1'b0; iv2 = 1'b0;
        tick();
        n_cmp++;
        if (obs4 !== 6'b000011) begin n_bad++; $display("FAIL post_reset4 got=%b exp=%b", obs4, 6'b000011); end
        n_cmp++;
        if (obs2 !== 6'b000011) begin n_bad++; $display("FAIL post_reset2 got=%b exp=%b", obs2, 6'b000011); end
        tick();
        n_cmp++;
        if (obs4 !== 6'b000011) begin n_bad++; $display("FAIL idle_hold4 got=%b exp=%b", obs4, 6'b000011); end
        oe_st4 = 1'b1; oe_st2 = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [13:0] b;
        logic [13:0] rise_ds = '0;
        int rises = 0, last_rise = -1;
        logic prev = 1'b0;
        sel4 = 6'b000001; seg4 = 8'hC0;
        b = frame_bits(sel4, seg4);
        wait_ready4();
        iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int o = 1; o <= 59; o++) begin
            logic [5:0] e;
            e = expect_at(b, o, 4, oe_st4);
            n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL single o=%0d got=%b exp=%b", o, obs4, e); end
            if (shcp4 && !prev) begin
                if (rises < 14) rise_ds[rises] = ds4;
                rises++;
                last_rise = o;
            end
            prev = shcp4;
            if (o < 59) tick();
        end
        oe_st4 = 1'b0;
        n_cmp++;
        if (rises !== 14) begin n_bad++; $display("FAIL single_rises got=%0d exp=14", rises); end
        n_cmp++;
        if (last_rise !== 55) begin n_bad++; $display("FAIL single_last_rise got=%0d exp=55", last_rise); end
        n_cmp++;
        if (rise_ds !== 14'h20C0) begin n_bad++; $display("FAIL single_ds_at_rise got=%h exp=%h", rise_ds, 14'h20C0); end
    endtask

    task automatic test_random_frames();
        repeat (4) begin
            logic [13:0] b;
            int gap;
            sel4 = 6'($urandom); seg4 = 8'($urandom);
            b = frame_bits(sel4, seg4);
            wait_ready4();
            iv4 = 1'b1;
            tick();
            iv4 = 1'b0;
            for (int o = 1; o <= 59; o++) begin
                logic [5:0] e;
                e = expect_at(b, o, 4, oe_st4);
                n_cmp++;
                if (obs4 !== e) begin n_bad++; $display("FAIL random o=%0d got=%b exp=%b", o, obs4, e); end
                if (o < 59) tick();
            end
            oe_st4 = 1'b0;
            gap = $urandom_range(1, 3);
            repeat (gap) begin
                tick();
                n_cmp++;
                if (obs4 !== 6'b000010) begin n_bad++; $display("FAIL random_idle got=%b exp=%b", obs4, 6'b000010); end
            end
        end
    endtask

    task automatic test_ignored_input();
        logic [13:0] b;
        sel4 = 6'($urandom); seg4 = 8'($urandom);
        b = frame_bits(sel4, seg4);
        wait_ready4();
        iv4 = 1'b1;
        tick();
        for (int o = 1; o <= 59; o++) begin
            logic [5:0] e;
            e = expect_at(b, o, 4, oe_st4);
            n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL ignored o=%0d got=%b exp=%b", o, obs4, e); end
            sel4 = 6'($urandom); seg4 = 8'($urandom);
            iv4 = (o < 58) ? 1'($urandom) : 1'b0;
            if (o < 59) tick();
        end
        oe_st4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [13:0] ba, bb;
        logic [5:0] sa, sb;
        logic [7:0] ga, gb;
        sa = 6'($urandom); ga = 8'($urandom);
        sb = ~sa; gb = ~ga;
        ba = frame_bits(sa, ga);
        bb = frame_bits(sb, gb);
        wait_ready4();
        sel4 = sa; seg4 = ga; iv4 = 1'b1;
        tick();
        for (int o = 1; o <= 59; o++) begin
            logic [5:0] e;
            e = expect_at(ba, o, 4, oe_st4);
            n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL b2b_a o=%0d got=%b exp=%b", o, obs4, e); end
            if (o == 59) begin sel4 = sb; seg4 = gb; end
            tick();
        end
        oe_st4 = 1'b0;
        for (int o = 1; o <= 59; o++) begin
            logic [5:0] e;
            e = expect_at(bb, o, 4, oe_st4);
            n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL b2b_b o=%0d got=%b exp=%b", o, obs4, e); end
            if (o == 58) iv4 = 1'b0;
            if (o < 59) tick();
        end
    endtask

    task automatic test_reset_midframe();
        logic [13:0] b;
        sel4 = 6'($urandom); seg4 = 8'($urandom);
        b = frame_bits(sel4, seg4);
        wait_ready4();
        iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int o = 1; o <= 20; o++) begin
            logic [5:0] e;
            e = expect_at(b, o, 4, oe_st4);
            n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL midrst_pre o=%0d got=%b exp=%b", o, obs4, e); end
            if (o < 20) tick();
        end
        rst4 = 1'b1;
        repeat (3) begin
            tick();
            n_cmp++;
            if (obs4 !== 6'b000001) begin n_bad++; $display("FAIL midrst_hold got=%b exp=%b", obs4, 6'b000001); end
        end
        rst4 = 1'b0;
        oe_st4 = 1'b1;
        tick();
        n_cmp++;
        if (obs4 !== 6'b000011) begin n_bad++; $display("FAIL midrst_release got=%b exp=%b", obs4, 6'b000011); end
        sel4 = 6'($urandom); seg4 = 8'($urandom);
        b = frame_bits(sel4, seg4);
        iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int o = 1; o <= 59; o++) begin
            logic [5:0] e;
            e = expect_at(b, o, 4, oe_st4);
            n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL midrst_post o=%0d got=%b exp=%b", o, obs4, e); end
            if (o < 59) tick();
        end
        oe_st4 = 1'b0;
    endtask

    task automatic test_div2();
        repeat (2) begin
            logic [13:0] b;
            int stcp_cycles = 0, done_at = -1;
            sel2 = 6'($urandom); seg2 = 8'($urandom);
            b = frame_bits(sel2, seg2);
            n_cmp++;
            if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL div2_ready got=%b exp=1", rdy2); end
            iv2 = 1'b1;
            tick();
            iv2 = 1'b0;
            for (int o = 1; o <= 30; o++) begin
                logic [5:0] e;
                e = expect_at(b, o, 2, oe_st2);
                n_cmp++;
                if (obs2 !== e) begin n_bad++; $display("FAIL div2 o=%0d got=%b exp=%b", o, obs2, e); end
                if (stcp2) stcp_cycles++;
                if (done2) done_at = o;
                if (o < 30) tick();
            end
            oe_st2 = 1'b0;
            n_cmp++;
            if (stcp_cycles !== 1) begin n_bad++; $display("FAIL div2_stcp_len got=%0d exp=1", stcp_cycles); end
            n_cmp++;
            if (done_at !== 30) begin n_bad++; $display("FAIL div2_done_at got=%0d exp=30", done_at); end
            tick();
        end
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        rst4 = 1'b1; rst2 = 1'b1; iv4 = 1'b0; iv2 = 1'b0;
        sel4 = '0; seg4 = '0; sel2 = '0; seg2 = '0;
        tick();
        test_reset();
        test_single_frame();
        test_random_frames();
        test_ignored_input();
        test_back_to_back();
        test_reset_midframe();
        test_div2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
